// File: rtl/vend_txn_ctrl.sv
// Per-purchase vending transaction controller: item lookup, stock check, coin
// collection against price*qty, a single dispense pulse, then change and status.
module vend_txn_ctrl #(
    parameter int unsigned item_addr          = 10,
    parameter int unsigned no_items_addr      = 8,
    parameter int unsigned total_amount_width = 15,
    parameter int unsigned LOOKUP_LAT         = 2,
    parameter int unsigned TIMEOUT_CYC        = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_mode,
    input  logic                          sel_valid,
    input  logic [item_addr-1:0]          sel_id,
    input  logic [no_items_addr-1:0]      sel_qty,
    input  logic                          coin_valid,
    input  logic [no_items_addr-1:0]      coin_value,
    input  logic                          cancel,
    output logic                          coin_ready,
    output logic                          busy,
    output logic [item_addr-1:0]          item_id,
    input  logic [no_items_addr-1:0]      avail_count,
    input  logic [no_items_addr-1:0]      item_price,
    output logic                          dispense_valid,
    output logic [no_items_addr-1:0]      no_items_dispensed,
    output logic                          txn_done,
    output logic [1:0]                    txn_status,
    output logic [total_amount_width:0]   change_amount
);

    localparam int unsigned CW = total_amount_width + 1;
    localparam int unsigned LW = $clog2(LOOKUP_LAT + 2);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    localparam logic [1:0] StatusOk      = 2'd0;
    localparam logic [1:0] StatusSoldOut = 2'd1;
    localparam logic [1:0] StatusCancel  = 2'd2;
    localparam logic [1:0] StatusTimeout = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StCheck,
        StCollect,
        StDispense,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [LW-1:0]            wait_q, wait_d;
    logic [TW-1:0]            timer_q, timer_d, timer_inc;
    logic [CW-1:0]            credit_q, credit_d, credit_sat, credit_new;
    logic [CW-1:0]            total_q, total_d;
    logic [CW:0]              credit_sum;
    logic [no_items_addr-1:0] qty_q, qty_d;
    logic [no_items_addr-1:0] price_q, price_d;
    logic [no_items_addr-1:0] avail_q, avail_d;
    logic [item_addr-1:0]     item_id_q, item_id_d;
    logic                     dispense_q, dispense_d;
    logic [no_items_addr-1:0] disp_qty_q, disp_qty_d;
    logic                     done_q, done_d;
    logic [1:0]               status_q, status_d;
    logic [CW-1:0]            change_q, change_d;

    assign busy               = (state_q != StIdle);
    assign coin_ready         = (state_q == StCollect) && !cfg_mode;
    assign item_id            = item_id_q;
    assign dispense_valid     = dispense_q;
    assign no_items_dispensed = disp_qty_q;
    assign txn_done           = done_q;
    assign txn_status         = status_q;
    assign change_amount      = change_q;

    // Credit saturates at all-ones rather than wrapping.
    assign credit_sum = (CW+1)'(credit_q) + (CW+1)'(coin_value);
    assign credit_sat = credit_sum[CW] ? {CW{1'b1}} : credit_sum[CW-1:0];
    assign credit_new = coin_valid ? credit_sat : credit_q;
    assign timer_inc  = timer_q + TW'(1);

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        timer_d    = timer_q;
        credit_d   = credit_q;
        total_d    = total_q;
        qty_d      = qty_q;
        price_d    = price_q;
        avail_d    = avail_q;
        item_id_d  = item_id_q;
        dispense_d = 1'b0;
        disp_qty_d = '0;
        done_d     = 1'b0;
        status_d   = status_q;
        change_d   = change_q;

        unique case (state_q)
            StIdle: begin
                if (sel_valid && !cfg_mode && (sel_qty != '0)) begin
                    item_id_d = sel_id;
                    qty_d     = sel_qty;
                    wait_d    = '0;
                    state_d   = StLookup;
                end
            end
            StLookup: begin
                if (wait_q == LW'(LOOKUP_LAT)) begin
                    avail_d = avail_count;
                    price_d = item_price;
                    state_d = StCheck;
                end else begin
                    wait_d = wait_q + LW'(1);
                end
            end
            StCheck: begin
                if (avail_q < qty_q) begin
                    status_d = StatusSoldOut;
                    change_d = '0;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end else begin
                    total_d  = CW'(price_q) * CW'(qty_q);
                    credit_d = '0;
                    timer_d  = '0;
                    state_d  = StCollect;
                end
            end
            StCollect: begin
                if (cfg_mode) begin
                    // Coins are not accepted while configuration is in progress.
                    status_d = StatusCancel;
                    change_d = credit_q;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end else if (cancel) begin
                    status_d = StatusCancel;
                    change_d = credit_new;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end else begin
                    credit_d = credit_new;
                    timer_d  = coin_valid ? '0 : timer_inc;
                    if (!coin_valid && (timer_inc == TW'(TIMEOUT_CYC - 1))) begin
                        status_d = StatusTimeout;
                        change_d = credit_q;
                        done_d   = 1'b1;
                        state_d  = StDone;
                    end else if (credit_new >= total_q) begin
                        dispense_d = 1'b1;
                        disp_qty_d = qty_q;
                        state_d    = StDispense;
                    end
                end
            end
            StDispense: begin
                status_d = StatusOk;
                change_d = credit_q - total_q;
                done_d   = 1'b1;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_q     <= '0;
            timer_q    <= '0;
            credit_q   <= '0;
            total_q    <= '0;
            qty_q      <= '0;
            price_q    <= '0;
            avail_q    <= '0;
            item_id_q  <= '0;
            dispense_q <= 1'b0;
            disp_qty_q <= '0;
            done_q     <= 1'b0;
            status_q   <= '0;
            change_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            timer_q    <= timer_d;
            credit_q   <= credit_d;
            total_q    <= total_d;
            qty_q      <= qty_d;
            price_q    <= price_d;
            avail_q    <= avail_d;
            item_id_q  <= item_id_d;
            dispense_q <= dispense_d;
            disp_qty_q <= disp_qty_d;
            done_q     <= done_d;
            status_q   <= status_d;
            change_q   <= change_d;
        end
    end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Self-checking bench for vend_txn_ctrl: item store model, table vectors,
// randomized purchases against a purchase-level model, and hand-written corner cases.
module tb_vend_txn_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst, cfg_mode, sel_valid, coin_valid, cancel;
    logic [9:0]  sel_id;
    logic [7:0]  sel_qty, coin_value;
    logic        coin_ready, busy, dispense_valid, txn_done;
    logic [9:0]  item_id;
    logic [7:0]  avail_count, item_price, no_items_dispensed;
    logic [1:0]  txn_status;
    logic [15:0] change_amount;

    always #5 clk = ~clk;

    vend_txn_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .sel_valid(sel_valid),
        .sel_id(sel_id), .sel_qty(sel_qty), .coin_valid(coin_valid),
        .coin_value(coin_value), .cancel(cancel), .coin_ready(coin_ready),
        .busy(busy), .item_id(item_id), .avail_count(avail_count),
        .item_price(item_price), .dispense_valid(dispense_valid),
        .no_items_dispensed(no_items_dispensed), .txn_done(txn_done),
        .txn_status(txn_status), .change_amount(change_amount)
    );

    // Item store: 2-cycle registered read, stock decremented on dispense.
    logic [7:0] stock [0:1023];
    logic [7:0] pmem  [0:1023];
    logic [7:0] rd_cnt, rd_price;
    logic       set_we = 1'b0;
    logic [9:0] set_id;
    logic [7:0] set_avail, set_price;

    always @(posedge clk) begin
        rd_cnt      <= stock[item_id];
        rd_price    <= pmem[item_id];
        avail_count <= rd_cnt;
        item_price  <= rd_price;
        if (set_we) begin
            stock[set_id] <= set_avail;
            pmem[set_id]  <= set_price;
        end else if (dispense_valid) begin
            stock[item_id] <= stock[item_id] - no_items_dispensed;
        end
    end

    int         done_cnt = 0, disp_cnt = 0, ready_cnt = 0;
    logic [1:0] last_status;
    int         last_change, last_qty;

    always @(negedge clk) begin
        if (txn_done) begin
            done_cnt    = done_cnt + 1;
            last_status = txn_status;
            last_change = int'(change_amount);
        end
        if (dispense_valid) begin
            disp_cnt = disp_cnt + 1;
            last_qty = int'(no_items_dispensed);
        end
        if (coin_ready) ready_cnt = ready_cnt + 1;
    end

    int checks = 0, failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_item(input int id, input int avail, input int price);
        set_we = 1'b1; set_id = 10'(id); set_avail = 8'(avail); set_price = 8'(price);
        step();
        set_we = 1'b0;
    endtask

    task automatic select(input int id, input int qty);
        sel_valid = 1'b1; sel_id = 10'(id); sel_qty = 8'(qty);
        step();
        sel_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int cyc = 0;
        while (!coin_ready && cyc < 20) begin step(); cyc++; end
        if (!coin_ready) check({name, "_ready_timeout"}, 0, 1);
    endtask

    task automatic coin(input int v, input logic with_cancel);
        coin_valid = 1'b1; coin_value = 8'(v); cancel = with_cancel;
        step();
        coin_valid = 1'b0; cancel = 1'b0;
    endtask

    // Runs one purchase from IDLE and returns once the controller is back in IDLE.
    task automatic run_txn(input int id, input int qty, input logic [3:0][7:0] coins,
                           input int ncoin, input int ck, output int st, output int ch,
                           output int nd, output int dq, output int nr);
        int d0, p0, r0, cyc, gap;
        d0 = done_cnt; p0 = disp_cnt; r0 = ready_cnt;
        select(id, qty);
        cyc = 0;
        while (!coin_ready && done_cnt == d0 && cyc < 20) begin step(); cyc++; end
        for (int k = 0; k < ncoin; k++) begin
            if (!coin_ready) break;
            coin(int'(coins[k]), k == ck);
            if (k == ck) break;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap && coin_ready; g++) step();
        end
        cyc = 0;
        while (done_cnt == d0 && cyc < 60) begin step(); cyc++; end
        check("txn_done_count", done_cnt - d0, 1);
        st = int'(last_status); ch = last_change; nd = disp_cnt - p0;
        dq = last_qty; nr = ready_cnt - r0;
    endtask

    // Purchase-level model: what the customer should get for this coin sequence.
    task automatic model(input int price, input int avail, input int qty,
                         input logic [3:0][7:0] coins, input int ncoin, input int ck,
                         output int st, output int ch, output int nd);
        int total, credit;
        total = price * qty;
        credit = 0;
        if (avail < qty) begin st = 1; ch = 0; nd = 0; return; end
        for (int k = 0; k < ncoin; k++) begin
            credit += int'(coins[k]);
            if (k == ck) begin st = 2; ch = credit; nd = 0; return; end
            if (credit >= total) begin st = 0; ch = credit - total; nd = 1; return; end
        end
        if (credit >= total) begin st = 0; ch = 0; nd = 1; end
        else begin st = 3; ch = credit; nd = 0; end
    endtask

    typedef struct {
        int              price, avail, qty, ncoin, ck;
        logic [3:0][7:0] coins;
        int              exp_st, exp_ch, exp_nd;
    } vec_t;

    vec_t vecs[8];

    task automatic set_vec(input int i, input int price, input int avail, input int qty,
                           input int n, input int c0, input int c1, input int c2,
                           input int ck, input int es, input int ec, input int ed);
        vecs[i].price = price; vecs[i].avail = avail; vecs[i].qty = qty;
        vecs[i].ncoin = n; vecs[i].ck = ck;
        vecs[i].coins = {8'd0, 8'(c2), 8'(c1), 8'(c0)};
        vecs[i].exp_st = es; vecs[i].exp_ch = ec; vecs[i].exp_nd = ed;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st, ch, nd, dq, nr, es, ec, ed, d0, n;
        logic [3:0][7:0] cs;

        rst = 1'b1; cfg_mode = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0; cancel = 1'b0;
        sel_id = '0; sel_qty = '0; coin_value = '0;
        step(); step();
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_coin_ready", int'(coin_ready), 0);
        check("rst_dispense", int'(dispense_valid), 0);
        check("rst_qty", int'(no_items_dispensed), 0);
        check("rst_done", int'(txn_done), 0);
        check("rst_status", int'(txn_status), 0);
        check("rst_change", int'(change_amount), 0);
        check("rst_item_id", int'(item_id), 0);

        set_vec(0, 25, 10, 2, 3, 20, 20, 20, -1, 0, 10, 1);
        set_vec(1, 10,  1, 3, 0,  0,  0,  0, -1, 1,  0, 0);
        set_vec(2, 50, 10, 1, 2, 30,  5,  0,  1, 2, 35, 0);
        set_vec(3, 50, 10, 1, 1,  5,  0,  0, -1, 3,  5, 0);
        set_vec(4, 40, 10, 1, 1, 40,  0,  0, -1, 0,  0, 1);
        set_vec(5,  0,  4, 2, 0,  0,  0,  0, -1, 0,  0, 1);
        set_vec(6,  7,  3, 3, 1, 21,  0,  0, -1, 0,  0, 1);
        set_vec(7,  9,  2, 3, 1, 30,  0,  0, -1, 1,  0, 0);

        for (int i = 0; i < 8; i++) begin
            set_item(10 + i, vecs[i].avail, vecs[i].price);
            run_txn(10 + i, vecs[i].qty, vecs[i].coins, vecs[i].ncoin, vecs[i].ck,
                    st, ch, nd, dq, nr);
            check($sformatf("vec%0d_status", i), st, vecs[i].exp_st);
            check($sformatf("vec%0d_change", i), ch, vecs[i].exp_ch);
            check($sformatf("vec%0d_dispense", i), nd, vecs[i].exp_nd);
            if (vecs[i].exp_nd == 1) check($sformatf("vec%0d_qty", i), dq, vecs[i].qty);
            if (vecs[i].exp_st == 1) check($sformatf("vec%0d_no_ready", i), nr, 0);
        end

        for (int i = 0; i < 40; i++) begin
            int price, avail, qty, nc, ck;
            price = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 60);
            avail = $urandom_range(0, 5);
            qty   = $urandom_range(1, 4);
            nc    = $urandom_range(0, 4);
            for (int k = 0; k < 4; k++) cs[k] = 8'($urandom_range(0, 80));
            ck = (nc > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, nc - 1) : -1;
            set_item(100 + i, avail, price);
            model(price, avail, qty, cs, nc, ck, es, ec, ed);
            run_txn(100 + i, qty, cs, nc, ck, st, ch, nd, dq, nr);
            check($sformatf("rnd%0d_status", i), st, es);
            check($sformatf("rnd%0d_change", i), ch, ec);
            check($sformatf("rnd%0d_dispense", i), nd, ed);
            if (ed == 1) check($sformatf("rnd%0d_qty", i), dq, qty);
        end

        // Exact payment, then immediate reselect must see the decremented stock.
        set_item(300, 1, 40);
        select(300, 1);
        wait_ready("exact");
        coin(40, 1'b0);
        check("exact_dispense_next", int'(dispense_valid), 1);
        check("exact_dispense_qty", int'(no_items_dispensed), 1);
        check("exact_item_id", int'(item_id), 300);
        step();
        check("exact_pulse_end", int'(dispense_valid), 0);
        check("exact_qty_clear", int'(no_items_dispensed), 0);
        check("exact_done", int'(txn_done), 1);
        check("exact_status", int'(txn_status), 0);
        check("exact_change", int'(change_amount), 0);
        step();
        check("exact_idle", int'(busy), 0);
        cs = '0;
        run_txn(300, 1, cs, 0, -1, st, ch, nd, dq, nr);
        check("reselect_soldout", st, 1);
        check("reselect_no_dispense", nd, 0);

        // Timeout latency measured from the last coin.
        set_item(400, 5, 50);
        select(400, 1);
        wait_ready("timeout");
        coin(5, 1'b0);
        n = 0;
        while (!txn_done && n < 40) begin step(); n++; end
        check("timeout_latency", n, TO - 1);
        check("timeout_status", int'(txn_status), 3);
        check("timeout_change", int'(change_amount), 5);
        step();

        // cfg_mode during collection drops coin_ready and aborts.
        set_item(450, 5, 50);
        select(450, 1);
        wait_ready("cfg");
        coin(10, 1'b0);
        cfg_mode = 1'b1;
        #1;
        check("cfg_coin_ready", int'(coin_ready), 0);
        step();
        cfg_mode = 1'b0;
        check("cfg_abort_done", int'(txn_done), 1);
        check("cfg_abort_status", int'(txn_status), 2);
        check("cfg_abort_change", int'(change_amount), 10);
        step();

        // Reset in the middle of collection discards credit silently.
        set_item(500, 5, 50);
        select(500, 1);
        wait_ready("rst");
        coin(20, 1'b0);
        step();
        check("rst_mid_busy_before", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        d0 = done_cnt;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_change", int'(change_amount), 0);
        check("rst_mid_done", int'(txn_done), 0);
        repeat (4) step();
        check("rst_mid_no_done", done_cnt - d0, 0);

        // Selections during cfg_mode or with zero quantity are ignored.
        cfg_mode = 1'b1;
        select(500, 1);
        check("cfg_sel_busy", int'(busy), 0);
        step();
        check("cfg_sel_busy_later", int'(busy), 0);
        cfg_mode = 1'b0;
        select(500, 0);
        check("zero_qty_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
